// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings, stage indices and mask helper for pipe_ctrl.
// Counter feature macro: PIPE_PERF_CNT_EN.
package pipe_ctrl_pkg;

  localparam logic [1:0] PIPE_RUN   = 2'd0;
  localparam logic [1:0] PIPE_DRAIN = 2'd1;
  localparam logic [1:0] PIPE_FLUSH = 2'd2;

  localparam int IF  = 0;
  localparam int ID  = 1;
  localparam int EXE = 2;
  localparam int MEM = 3;
  localparam int WB  = 4;

  // bits 0..hi set; hi < 0 gives an empty mask
  function automatic logic [7:0] low_mask(input int hi);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++)
      m[i] = (i <= hi);
    return m;
  endfunction

endpackage

// File: rtl/pipe_hold_chain.sv
// Combinational hold chain, load enables and bubble insertion
// for the pipeline sequencing controller.
module pipe_hold_chain
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES = 5
) (
  input  logic [STAGES-1:0] stall_req,
  input  logic [STAGES-1:0] valid,
  input  logic [STAGES-1:0] freeze,
  input  logic [STAGES-1:0] force_ld,
  output logic [STAGES-1:0] hold,
  output logic [STAGES-1:0] en,
  output logic [STAGES-1:0] bub
);

  // an empty stage absorbs the hold from downstream
  always_comb begin
    hold = '0;
    hold[STAGES-1] = stall_req[STAGES-1];
    for (int i = STAGES-2; i >= 0; i--)
      hold[i] = stall_req[i]
              | (valid[i] & hold[i+1]);
  end

  assign en = force_ld | (~hold & ~freeze);

  always_comb begin
    bub = force_ld;
    for (int i = 1; i < STAGES; i++)
      bub[i] = force_ld[i]
             | (en[i] & (~en[i-1] | ~valid[i-1]));
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: enables, bubbles, valid tracking
// and drain/flush exception FSM. Optional macro: PIPE_PERF_CNT_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES         = 5,
  parameter int EXC_STAGE      = 3,
  parameter int REDIRECT_STAGE = 1,
  parameter int DELAY_SLOT     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [STAGES-1:0] stall_req,
  input  logic              exc_req,
  input  logic              redirect,
  output logic [STAGES-1:0] stage_en,
  output logic [STAGES-1:0] stage_rst,
  output logic [STAGES-1:0] stage_valid,
  output logic [STAGES-1:0] stage_lock,
  output logic              exc_commit,
  output logic              draining,
  input  logic [2:0]        perf_sel,
  output logic [31:0]       perf_data
);

  localparam int FL_HI = REDIRECT_STAGE - 1 - DELAY_SLOT;

  localparam logic [7:0] EXC_M8 = low_mask(EXC_STAGE);
  localparam logic [7:0] RDR_M8 = low_mask(FL_HI);
  localparam logic [7:0] NXT_M8 = 8'd1 << (EXC_STAGE + 1);

  localparam logic [STAGES-1:0] EXC_M = EXC_M8[STAGES-1:0];
  localparam logic [STAGES-1:0] RDR_M = RDR_M8[STAGES-1:0];
  localparam logic [STAGES-1:0] NXT_M = NXT_M8[STAGES-1:0];

  logic [1:0]        state_q, state_d;
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] hold, en, bub;
  logic [STAGES-1:0] freeze, force_ld;
  logic              in_run, in_drain, in_flush;
  logic              exc_go, rdr_go, stall_clr;

  assign in_run   = (state_q == PIPE_RUN);
  assign in_drain = (state_q == PIPE_DRAIN);
  assign in_flush = (state_q == PIPE_FLUSH);

  assign exc_go = in_run & exc_req
                & valid_q[EXC_STAGE];

  assign rdr_go = in_run & ~exc_go & redirect
                & valid_q[REDIRECT_STAGE]
                & ~hold[REDIRECT_STAGE];

  assign stall_clr = ~|(stall_req & EXC_M);

  // freeze already on the detect cycle so the
  // faulting instruction never leaves EXC_STAGE
  always_comb begin
    freeze = '0;
    if (in_drain | exc_go)
      freeze = EXC_M;
    else if (in_flush)
      freeze = NXT_M;
  end

  always_comb begin
    force_ld = '0;
    if (in_flush)
      force_ld = EXC_M;
    else if (rdr_go)
      force_ld = RDR_M;
  end

  pipe_hold_chain #(
    .STAGES(STAGES)
  ) u_hold (
    .stall_req(stall_req),
    .valid    (valid_q),
    .freeze   (freeze),
    .force_ld (force_ld),
    .hold     (hold),
    .en       (en),
    .bub      (bub)
  );

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      in_run:   if (exc_go) state_d = PIPE_DRAIN;
      in_drain: if (stall_clr) state_d = PIPE_FLUSH;
      in_flush: state_d = PIPE_RUN;
      default:  state_d = PIPE_RUN;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    valid_d[0] = 1'b1;
    for (int i = 1; i < STAGES; i++)
      if (en[i])
        valid_d[i] = valid_q[i-1] & ~bub[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PIPE_RUN;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    stage_valid = valid_q & {STAGES{rst_n}};
    stage_valid[0] = valid_q[0] & rst_n & ~in_flush;
  end

  assign stage_en   = en & {STAGES{rst_n}};
  assign stage_rst  = bub | {STAGES{~rst_n}};
  assign stage_lock = ~stage_en;
  assign exc_commit = in_flush & rst_n;
  assign draining   = in_drain & rst_n;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cnt_q [STAGES];
  logic [31:0] cnt_d [STAGES];

  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (hold[i] & valid_q[i] & ~&cnt_q[i])
        cnt_d[i] = cnt_q[i] + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++)
        cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    perf_data = '0;
    for (int i = 0; i < STAGES; i++)
      if (perf_sel == 3'(i))
        perf_data = cnt_q[i];
  end
`else
  logic unused_perf;
  assign unused_perf = ^perf_sel;
  assign perf_data   = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: default build plus a second
// instance with REDIRECT_STAGE=2, DELAY_SLOT=0 on shared inputs.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] stall_req;
  logic       exc_req;
  logic       redirect;
  logic [2:0] perf_sel;

  logic [4:0]  en, rs, va, lk;
  logic        xc, dr;
  logic [31:0] pd;
  logic [4:0]  en2, rs2, va2, lk2;
  logic        xc2, dr2;
  logic [31:0] pd2;

  int n_cmp = 0;
  int n_err = 0;

`ifdef PIPE_PERF_CNT_EN
  localparam logic [31:0] PERF_EXP = 32'd3;
`else
  localparam logic [31:0] PERF_EXP = 32'd0;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(
    .STAGES(5), .EXC_STAGE(3),
    .REDIRECT_STAGE(1), .DELAY_SLOT(1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .stall_req(stall_req), .exc_req(exc_req),
    .redirect(redirect),
    .stage_en(en), .stage_rst(rs),
    .stage_valid(va), .stage_lock(lk),
    .exc_commit(xc), .draining(dr),
    .perf_sel(perf_sel), .perf_data(pd)
  );

  pipe_ctrl #(
    .STAGES(5), .EXC_STAGE(3),
    .REDIRECT_STAGE(2), .DELAY_SLOT(0)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .stall_req(stall_req), .exc_req(exc_req),
    .redirect(redirect),
    .stage_en(en2), .stage_rst(rs2),
    .stage_valid(va2), .stage_lock(lk2),
    .exc_commit(xc2), .draining(dr2),
    .perf_sel(perf_sel), .perf_data(pd2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    stall_req = '0;
    exc_req = 1'b0;
    redirect = 1'b0;
    perf_sel = 3'd3;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({en, rs, va, lk} !== {5'b00000, 5'b11111, 5'b00000, 5'b11111}) begin
      n_err++;
      $display("FAIL reset_vec en/rst/valid/lock got %b %b %b %b want 00000 11111 00000 11111", en, rs, va, lk);
    end
    n_cmp++;
    if ({xc, dr, pd} !== {1'b0, 1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL reset_misc commit/drain/perf got %b %b %0d want 0 0 0", xc, dr, pd);
    end
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (va !== 5'b00000 || en !== 5'b11111) begin
      n_err++;
      $display("FAIL release valid/en got %b %b want 00000 11111", va, en);
    end
  endtask

  task automatic test_fill();
    logic [4:0] exp_v;
    for (int k = 1; k <= 5; k++) begin
      step();
      @(negedge clk);
      exp_v = 5'((1 << k) - 1);
      n_cmp++;
      if (va !== exp_v || en !== 5'b11111) begin
        n_err++;
        $display("FAIL fill_%0d valid/en got %b %b want %b 11111", k, va, en, exp_v);
      end
    end
    n_cmp++;
    if (rs !== 5'b00000 || lk !== 5'b00000) begin
      n_err++;
      $display("FAIL fill_done rst/lock got %b %b want 00000 00000", rs, lk);
    end
  endtask

  task automatic test_stall();
    logic [4:0] exp_v;
    for (int k = 0; k < 3; k++) begin
      step();
      stall_req = 5'b01000;
      @(negedge clk);
      exp_v = (k == 0) ? 5'b11111 : 5'b01111;
      n_cmp++;
      if (en !== 5'b10000 || rs !== 5'b10000 || va !== exp_v) begin
        n_err++;
        $display("FAIL stall_%0d en/rst/valid got %b %b %b want 10000 10000 %b", k, en, rs, va, exp_v);
      end
    end
    step();
    stall_req = '0;
    @(negedge clk);
    n_cmp++;
    if (en !== 5'b11111 || rs !== 5'b00000 || va !== 5'b01111) begin
      n_err++;
      $display("FAIL stall_rel en/rst/valid got %b %b %b want 11111 00000 01111", en, rs, va);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (va !== 5'b11111) begin
      n_err++;
      $display("FAIL stall_resume valid got %b want 11111", va);
    end
    n_cmp++;
    if (pd !== PERF_EXP) begin
      n_err++;
      $display("FAIL perf_stage3 got %0d want %0d", pd, PERF_EXP);
    end
  endtask

  task automatic test_collapse();
    step();
    stall_req = 5'b00010;
    @(negedge clk);
    n_cmp++;
    if (en !== 5'b11100 || rs !== 5'b00100) begin
      n_err++;
      $display("FAIL mk_bubble en/rst got %b %b want 11100 00100", en, rs);
    end
    step();
    stall_req = 5'b10000;
    @(negedge clk);
    n_cmp++;
    if (va !== 5'b11011 || en !== 5'b00111 || rs !== 5'b00000) begin
      n_err++;
      $display("FAIL collapse valid/en/rst got %b %b %b want 11011 00111 00000", va, en, rs);
    end
    step();
    stall_req = '0;
    @(negedge clk);
    n_cmp++;
    if (va !== 5'b11111 || en !== 5'b11111) begin
      n_err++;
      $display("FAIL collapse_fill valid/en got %b %b want 11111 11111", va, en);
    end
  endtask

  task automatic test_exc();
    int nd;
    nd = 0;
    step();
    exc_req = 1'b1;
    stall_req = 5'b00001;
    @(negedge clk);
    n_cmp++;
    if (en !== 5'b10000 || dr !== 1'b0 || xc !== 1'b0) begin
      n_err++;
      $display("FAIL exc_detect en/drain/commit got %b %b %b want 10000 0 0", en, dr, xc);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      exc_req = 1'b0;
      stall_req = (k < 3) ? 5'b00001 : 5'b00000;
      @(negedge clk);
      if (dr === 1'b1) nd++;
      n_cmp++;
      if (en !== 5'b10000 || xc !== 1'b0 || va !== 5'b01111) begin
        n_err++;
        $display("FAIL drain_%0d en/commit/valid got %b %b %b want 10000 0 01111", k, en, xc, va);
      end
    end
    n_cmp++;
    if (nd !== 4) begin
      n_err++;
      $display("FAIL drain_len got %0d want 4", nd);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (xc !== 1'b1 || rs !== 5'b01111 || en !== 5'b01111 || dr !== 1'b0) begin
      n_err++;
      $display("FAIL flush commit/rst/en/drain got %b %b %b %b want 1 01111 01111 0", xc, rs, en, dr);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (va !== 5'b00001 || xc !== 1'b0) begin
      n_err++;
      $display("FAIL post_flush valid/commit got %b %b want 00001 0", va, xc);
    end
  endtask

  task automatic test_redirect();
    for (int k = 0; k < 4; k++) step();
    @(negedge clk);
    n_cmp++;
    if (va !== 5'b11111 || va2 !== 5'b11111) begin
      n_err++;
      $display("FAIL refill valid/valid2 got %b %b want 11111 11111", va, va2);
    end
    step();
    redirect = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rs2 !== 5'b00011 || en2 !== 5'b11111 || rs !== 5'b00000) begin
      n_err++;
      $display("FAIL redirect rst2/en2/rst got %b %b %b want 00011 11111 00000", rs2, en2, rs);
    end
    step();
    redirect = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (va2 !== 5'b11101 || va !== 5'b11111) begin
      n_err++;
      $display("FAIL redirect_valid valid2/valid got %b %b want 11101 11111", va2, va);
    end
  endtask

  task automatic test_exc_redirect();
    step();
    exc_req = 1'b1;
    redirect = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rs2 !== 5'b10000 || en2 !== 5'b10000) begin
      n_err++;
      $display("FAIL exc_wins rst2/en2 got %b %b want 10000 10000", rs2, en2);
    end
    step();
    exc_req = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dr2 !== 1'b1 || xc2 !== 1'b0) begin
      n_err++;
      $display("FAIL exc_wins_drain drain2/commit2 got %b %b want 1 0", dr2, xc2);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (xc2 !== 1'b1 || rs2 !== 5'b01111) begin
      n_err++;
      $display("FAIL exc_wins_flush commit2/rst2 got %b %b want 1 01111", xc2, rs2);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (va2 !== 5'b00001 || va !== 5'b00001) begin
      n_err++;
      $display("FAIL exc_wins_post valid2/valid got %b %b want 00001 00001", va2, va);
    end
  endtask

  task automatic test_rst_drain();
    int nc;
    nc = 0;
    for (int k = 0; k < 4; k++) step();
    exc_req = 1'b1;
    stall_req = 5'b00001;
    step();
    exc_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dr !== 1'b1) begin
      n_err++;
      $display("FAIL rd_enter drain got %b want 1", dr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({en, rs, va, lk} !== {5'b00000, 5'b11111, 5'b00000, 5'b11111}) begin
      n_err++;
      $display("FAIL rd_async en/rst/valid/lock got %b %b %b %b want 00000 11111 00000 11111", en, rs, va, lk);
    end
    n_cmp++;
    if ({xc, dr, pd} !== {1'b0, 1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL rd_async commit/drain/perf got %b %b %0d want 0 0 0", xc, dr, pd);
    end
    stall_req = '0;
    step();
    if (xc !== 1'b0) nc++;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (xc !== 1'b0 || dr !== 1'b0) nc++;
      step();
    end
    n_cmp++;
    if (nc !== 0) begin
      n_err++;
      $display("FAIL rd_no_commit stray commit/drain cycles got %0d want 0", nc);
    end
    @(negedge clk);
    n_cmp++;
    if (va !== 5'b11111 || en !== 5'b11111) begin
      n_err++;
      $display("FAIL rd_run valid/en got %b %b want 11111 11111", va, en);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stall();
    test_collapse();
    test_exc();
    test_redirect();
    test_exc_redirect();
    test_rst_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
